// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dmem arbiter slice.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_P = 1'b0,
    OWN_H = 1'b1
  } owner_t;

  localparam int unsigned MAX_READ_LAT = 4;
  localparam int unsigned CNT_W        = $clog2(MAX_READ_LAT + 1);

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on contention the port that did not own the last access wins.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic   req_p,
  input  logic   req_h,
  input  owner_t last_owner,
  output logic   any,
  output owner_t owner
);

  always_comb begin
    any   = req_p | req_h;
    owner = OWN_P;
    if (req_p && req_h) begin
      if (last_owner == OWN_P) owner = OWN_H;
      else                     owner = OWN_P;
    end else if (req_h) begin
      owner = OWN_H;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises processor (P) and host (H) accesses onto the single-port dmem,
// one access in flight, round-robin on contention, fixed read latency.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_wren,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              h_req,
  input  logic              h_wren,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  if (READ_LAT < 1 || READ_LAT > int'(MAX_READ_LAT)) begin : g_bad_read_lat
    $error("dmem_arbiter: READ_LAT must be in 1..4");
  end

  state_t           state_q, state_d;
  owner_t           owner_q, last_owner_q, pick_owner;
  logic             pick_any;
  logic             cmd_wren_q;
  logic [CNT_W-1:0] cnt_q;

  rr_pick2 u_pick (
    .req_p      (p_req),
    .req_h      (h_req),
    .last_owner (last_owner_q),
    .any        (pick_any),
    .owner      (pick_owner)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_any) state_d = ST_ISSUE;
      ST_ISSUE: state_d = cmd_wren_q ? ST_IDLE : ST_WAIT;
      ST_WAIT:  if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    p_gnt    = (state_q == ST_ISSUE) && (owner_q == OWN_P);
    h_gnt    = (state_q == ST_ISSUE) && (owner_q == OWN_H);
    mem_wren = (state_q == ST_ISSUE) && cmd_wren_q;
    busy     = (state_q != ST_IDLE);
  end

  // The command latch doubles as the dmem address/data register, so the bus
  // carries the new command in ISSUE and holds it afterwards.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_P;
      last_owner_q <= OWN_H;
      cmd_wren_q   <= 1'b0;
      cnt_q        <= '0;
      mem_address  <= '0;
      mem_data     <= '0;
      p_rvalid     <= 1'b0;
      h_rvalid     <= 1'b0;
      p_rdata      <= '0;
      h_rdata      <= '0;
    end else begin
      state_q  <= state_d;
      p_rvalid <= 1'b0;
      h_rvalid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            owner_q <= pick_owner;
            if (pick_owner == OWN_H) begin
              cmd_wren_q  <= h_wren;
              mem_address <= h_addr;
              mem_data    <= h_wdata;
            end else begin
              cmd_wren_q  <= p_wren;
              mem_address <= p_addr;
              mem_data    <= p_wdata;
            end
          end
        end
        ST_ISSUE: begin
          last_owner_q <= owner_q;
          if (!cmd_wren_q) cnt_q <= CNT_W'(READ_LAT);
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (owner_q == OWN_H) begin
              h_rdata  <= mem_q;
              h_rvalid <= 1'b1;
            end else begin
              p_rdata  <= mem_q;
              p_rvalid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous dmem between two requesters: the processor (port P) and a host/loader port (port H) used for program/data preload and debug readback.
- Sits between the processor's dmem outputs and the dmem syncram.
- Serialises accesses, with 2-way round-robin priority and fixed-latency read return.
- Exactly one access is in flight at a time.

Parameters:
- ADDR_W, 12, address width (matches dmem depth).
- DATA_W, 32, data word width.
- READ_LAT, 1, cycles from the ISSUE clock edge until mem_q is valid. Legal range 1..4; other values are a configuration error.

Ports:
- clock  in  1  single clock for the block.
- reset  in  1  synchronous, active-low; sampled only on the rising edge of clock.
- p_req  in  1  processor request; held until p_gnt.
- p_wren  in  1  processor access type: 1 = write, 0 = read.
- p_addr  in  ADDR_W  processor address.
- p_wdata  in  DATA_W  processor write data.
- p_gnt  out  1  one-cycle pulse: processor command issued.
- p_rvalid  out  1  one-cycle pulse: p_rdata valid.
- p_rdata  out  DATA_W  processor read data.
- h_req, h_wren, h_addr, h_wdata, h_gnt, h_rvalid, h_rdata: same as the p_* ports, for the host port.
- mem_address  out  ADDR_W  to dmem address.
- mem_data  out  DATA_W  to dmem data.
- mem_wren  out  1  to dmem wren.
- mem_q  in  DATA_W  from dmem q.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE.
  - All outputs go to 0, including mem_address, mem_data, rdata and busy.
  - last_owner is set to H, so the first contention goes to P.
  - Any read in flight is dropped; no rvalid is produced for it.
  - Reset dominates every other event in the same cycle.
- States are IDLE, ISSUE, WAIT.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If one req is high, latch that owner and its wren/addr/wdata, then go to ISSUE.
  - If both are high, the winner is the port that is not last_owner. Latch it and go to ISSUE. The loser keeps req high and is served next.
- ISSUE (exactly 1 cycle):
  - mem_address, mem_data and mem_wren are driven from the latched command.
  - The owner's gnt is 1; the other port's gnt is 0.
  - last_owner is updated to the owner.
  - On a write, the next state is IDLE.
  - On a read, the next state is WAIT with the counter loaded to READ_LAT.
- WAIT:
  - The counter decrements each cycle.
  - In the cycle where the counter reaches 1, mem_q is captured into the owner's rdata register. The next state is IDLE, and the owner's rvalid is 1 during that IDLE cycle.
- Read latency: a request sampled at edge T gives ISSUE in T+1 and rvalid in T+2+READ_LAT. With READ_LAT=1, rvalid arrives 3 cycles after req.
- Write occupancy: 2 cycles (IDLE, then ISSUE).
- rvalid and a new IDLE arbitration decision may occur in the same cycle; back-to-back operation is allowed.
- rdata holds its last captured value until the next read for that port. The other port's rdata is unaffected.
- mem_wren is 1 only in ISSUE with a latched write; it is 0 in all other states.
- mem_address and mem_data hold the last issued values outside ISSUE.
- Requester rules:
  - addr, wren and wdata must be stable from req rise through the gnt cycle.
  - req still high in the cycle after gnt counts as a new request.
  - req dropped before gnt is permitted. The latched command still completes, since it is latched at the IDLE decision.
- Fairness: under continuous contention, grants alternate P, H, P, H. Neither port waits more than one full access of the other.
- A single requester asserting continuously is granted every 2 cycles (writes) or every READ_LAT+2 cycles (reads).

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state encoding constants ST_IDLE, ST_ISSUE, ST_WAIT;
  - owner constants OWN_P=0, OWN_H=1;
  - the counter width derived from a max READ_LAT of 4 (3 bits).
- One sub-module, rr_pick2: a combinational 2-way round-robin picker with inputs (req_p, req_h, last_owner) and outputs (any, owner).
- The FSM, command latch and counter stay in dmem_arbiter.

Test Plan:
- Reset, then P read addr 0x010, with dmem preloaded [0x010]=0xDEADBEEF and READ_LAT=1:
  - p_gnt in cycle 2;
  - mem_address=0x010 and mem_wren=0 in that cycle;
  - p_rvalid=1 with p_rdata=0xDEADBEEF in cycle 4;
  - h_* outputs stay 0 throughout.
- H write 0x0AB←0x12345678, then P read 0x0AB:
  - mem_wren=1 for exactly one cycle;
  - the P read returns 0x12345678.
- P and H both assert read req in the same cycle after reset:
  - P is granted first, H second;
  - continuous contention for 6 accesses gives the grant sequence P,H,P,H,P,H.
- Reset asserted (reset=0) during WAIT of an H read:
  - no h_rvalid occurs;
  - all outputs are 0 the next cycle;
  - a subsequent P read completes normally.
- READ_LAT=3, P read 0xFFF with [0xFFF]=0xA5A5A5A5:
  - p_rvalid arrives exactly 5 cycles after the req sampling edge;
  - busy is high for 4 cycles.
- P holds req for back-to-back writes 0x001←1 and 0x002←2:
  - p_gnt pulses 2 cycles apart;
  - mem_wren is never high outside those gnt cycles.
